led_display_frame_writer: RTL and testbench
===========================================

Name: led_display_frame_writer

Overview:
Write-side counterpart to led_display_ram_control. It accepts a raster pixel stream on a valid/ready interface, with a start-of-frame marker, and writes one pixel per word into frame_ram port A. The RAM is double-buffered: the block always fills the back bank, and it swaps banks only when the reader signals the end of a displayed frame. The reader therefore never displays a partially written frame.

Parameters:
NUM_ROW_PIXELS, 32, panel rows
NUM_COL_PIXELS, 64, panel columns
RAM_ADDR_WIDTH, 13, frame_ram address width
RAM_DATA_WIDTH, 32, frame_ram word width; must be >= 24

Ports:
clk_in  in  1  system clock
reset_in  in  1  asynchronous, active-high reset
pixel_in  in  24  pixel {R[23:16], G[15:8], B[7:0]}
pixel_valid_in  in  1  pixel_in valid
pixel_sof_in  in  1  qualifies the first pixel of a frame (sampled with valid)
pixel_ready_out  out  1  block can accept a pixel
pattern_start_in  in  1  test-pattern request (see Optional Feature)
frame_sync_in  in  1  one-cycle pulse from the reader at end of a displayed frame
ram_write_en_out  out  1  RAM write strobe
ram_address_out  out  RAM_ADDR_WIDTH  RAM write address
ram_wdata_out  out  RAM_DATA_WIDTH  RAM write data, {zero pad, pixel}
display_bank_out  out  1  bank the reader must display
frame_done_out  out  1  one-cycle pulse: back bank fully written
sof_error_out  out  1  sticky: SOF seen mid-frame; cleared only by reset

Behaviour:
- Derived constants: FRAME_WORDS = NUM_ROW_PIXELS*NUM_COL_PIXELS; elaboration error if 2*FRAME_WORDS > 2**RAM_ADDR_WIDTH.
- Address computation:
  - address = wbank*FRAME_WORDS + row*NUM_COL_PIXELS + col.
  - wbank = ~display_bank_out at all times.
  - col increments first, wraps at NUM_COL_PIXELS-1 and increments row.
- Handshake:
  - A pixel is accepted when pixel_valid_in && pixel_ready_out.
  - All RAM outputs are registered; the write occurs the cycle after acceptance (latency 1).
  - ram_write_en_out is high for exactly one cycle per written pixel.
  - Address and data outputs hold their last value when the strobe is low.
- FSM states:
  - IDLE: ready=1.
    - Accepted pixel with sof=1 -> write it at (0,0) -> WRITE.
    - Accepted pixel with sof=0 -> consumed and discarded, no write.
  - WRITE: ready=1.
    - Each accepted pixel is written at the current (row,col).
    - Accepted sof=1 -> set sof_error_out, restart at (0,0) with this pixel, stay in WRITE.
    - Acceptance of pixel FRAME_WORDS-1 -> WAIT_SWAP.
  - WAIT_SWAP: ready=0.
    - frame_done_out pulses on the cycle the last write strobe is high.
    - On frame_sync_in: toggle display_bank_out, clear counters -> IDLE.
- Ignored sync:
  - frame_sync_in in IDLE or WRITE is ignored.
  - frame_sync_in on the same cycle as the last-pixel acceptance is ignored; the block waits for the next sync.
- Reset values:
  - All outputs 0; display_bank_out=0, so the first frame is written to bank 1.
  - Counters 0, state IDLE.
  - Reset mid-frame abandons the frame with no further writes.

Optional Feature:
Macro LED_FRAME_WRITER_PATTERN_EN.
- Defined:
  - pattern_start_in high in IDLE starts an internal generator that writes a full frame, one word per cycle, with pixel_ready_out=0 throughout.
  - Pattern pixel = {R=col*4 (8b), G=row*8 (8b), B=8'h00}.
  - Writes use the same addressing, frame_done_out and WAIT_SWAP flow as a streamed frame.
  - If pattern_start_in and an SOF pixel arrive together in IDLE, the pattern wins and the pixel is not accepted.
- Undefined: pattern_start_in is ignored and the generator is not built.

Test Plan:
1. Reset, then stream 2048 pixels (value = index, first with sof=1, no stalls) -> 2048 strobes at addresses 0x800..0xFFF with data equal to the index; frame_done_out pulses once with the 0xFFF write; ready drops.
2. After test 1, pulse frame_sync_in -> display_bank_out=1 and ready=1; the next frame writes 0x000..0x7FF.
3. Send 5 pixels with sof=0 in IDLE -> no writes; ready stays 1.
4. 100 pixels into a frame, assert sof=1 on the next pixel -> sof_error_out=1; that pixel is written at 0x800.
5. Pulse frame_sync_in on the last-pixel acceptance cycle -> no swap; a later sync swaps the bank.
6. Assert reset_in mid-frame at pixel 300 -> all outputs 0 immediately; a new SOF frame starts at 0x800. With LED_FRAME_WRITER_PATTERN_EN defined, pattern_start_in -> word (3,5) at 0x800+3*64+5 = 0x8C5 holds 24'h141800.

Source files
------------

// File: rtl/led_display_frame_writer.sv
// Raster pixel stream -> double-buffered frame_ram writer; fills the back bank, swaps on reader sync.
// Optional test-pattern generator: define LED_FRAME_WRITER_PATTERN_EN.
module led_display_frame_writer #(
   parameter int NUM_ROW_PIXELS = 32,
   parameter int NUM_COL_PIXELS = 64,
   parameter int RAM_ADDR_WIDTH = 13,
   parameter int RAM_DATA_WIDTH = 32
) (
   input  logic                      clk_in,
   input  logic                      reset_in,
   input  logic [23:0]               pixel_in,
   input  logic                      pixel_valid_in,
   input  logic                      pixel_sof_in,
   output logic                      pixel_ready_out,
   input  logic                      pattern_start_in,
   input  logic                      frame_sync_in,
   output logic                      ram_write_en_out,
   output logic [RAM_ADDR_WIDTH-1:0] ram_address_out,
   output logic [RAM_DATA_WIDTH-1:0] ram_wdata_out,
   output logic                      display_bank_out,
   output logic                      frame_done_out,
   output logic                      sof_error_out
);

   localparam int FRAME_WORDS = NUM_ROW_PIXELS * NUM_COL_PIXELS;
   localparam int ROW_W = (NUM_ROW_PIXELS > 1) ? $clog2(NUM_ROW_PIXELS) : 1;
   localparam int COL_W = (NUM_COL_PIXELS > 1) ? $clog2(NUM_COL_PIXELS) : 1;
   localparam logic [RAM_ADDR_WIDTH-1:0] FRAME_A = RAM_ADDR_WIDTH'(FRAME_WORDS);
   localparam logic [RAM_ADDR_WIDTH-1:0] COLS_A  = RAM_ADDR_WIDTH'(NUM_COL_PIXELS);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROW_PIXELS - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COL_PIXELS - 1);

   generate
      if (2 * FRAME_WORDS > 2 ** RAM_ADDR_WIDTH) begin : g_addr_chk
         $error("led_display_frame_writer: two frames do not fit in RAM_ADDR_WIDTH");
      end
      if (RAM_DATA_WIDTH < 24) begin : g_data_chk
         $error("led_display_frame_writer: RAM_DATA_WIDTH must be >= 24");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_WAIT_SWAP
`ifdef LED_FRAME_WRITER_PATTERN_EN
      , S_PATTERN
`endif
   } state_t;

   state_t                    state_q, state_d;
   logic [ROW_W-1:0]          row_q, row_d;
   logic [COL_W-1:0]          col_q, col_d;
   logic                      bank_q, bank_d;
   logic                      ready_q, ready_d;
   logic                      we_q, we_d;
   logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [RAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                      done_q, done_d;
   logic                      sof_err_q, sof_err_d;

   logic                      accept;
   logic                      pat_active;
   logic                      restart;
   logic                      write_req;
   logic [ROW_W-1:0]          pos_row;
   logic [COL_W-1:0]          pos_col;
   logic                      pos_last;
   logic [23:0]               pat_pix;

`ifdef LED_FRAME_WRITER_PATTERN_EN
   // A pattern request in IDLE masks ready so a simultaneous SOF pixel is refused.
   assign pixel_ready_out = ready_q && !(state_q == S_IDLE && pattern_start_in);
   assign pat_active      = (state_q == S_PATTERN);
`else
   logic unused_pattern_start;
   assign unused_pattern_start = pattern_start_in;
   assign pixel_ready_out      = ready_q;
   assign pat_active           = 1'b0;
`endif

   assign accept   = pixel_valid_in && pixel_ready_out;
   assign restart  = pixel_sof_in && !pat_active;
   assign pos_row  = restart ? '0 : row_q;
   assign pos_col  = restart ? '0 : col_q;
   assign pos_last = (pos_row == LAST_ROW) && (pos_col == LAST_COL);
   assign pat_pix  = {8'(32'(pos_col) * 4), 8'(32'(pos_row) * 8), 8'h00};

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      bank_d    = bank_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      sof_err_d = sof_err_q;
      we_d      = 1'b0;
      done_d    = 1'b0;
      write_req = 1'b0;

      case (state_q)
         S_IDLE: begin
`ifdef LED_FRAME_WRITER_PATTERN_EN
            if (pattern_start_in) begin
               state_d = S_PATTERN;
               row_d   = '0;
               col_d   = '0;
            end else
`endif
            if (accept && pixel_sof_in) begin
               write_req = 1'b1;
            end
         end
         S_WRITE: begin
            if (accept) begin
               write_req = 1'b1;
               if (pixel_sof_in) begin
                  sof_err_d = 1'b1;
               end
            end
         end
         S_WAIT_SWAP: begin
            if (frame_sync_in) begin
               bank_d  = ~bank_q;
               row_d   = '0;
               col_d   = '0;
               state_d = S_IDLE;
            end
         end
`ifdef LED_FRAME_WRITER_PATTERN_EN
         S_PATTERN: begin
            write_req = 1'b1;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (write_req) begin
         we_d    = 1'b1;
         addr_d  = (bank_q ? '0 : FRAME_A) + RAM_ADDR_WIDTH'(pos_row) * COLS_A
                   + RAM_ADDR_WIDTH'(pos_col);
         wdata_d = RAM_DATA_WIDTH'(pat_active ? pat_pix : pixel_in);
         if (pos_last) begin
            done_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
            state_d = S_WAIT_SWAP;
         end else begin
            if (pos_col == LAST_COL) begin
               col_d = '0;
               row_d = pos_row + 1'b1;
            end else begin
               col_d = pos_col + 1'b1;
               row_d = pos_row;
            end
`ifdef LED_FRAME_WRITER_PATTERN_EN
            state_d = pat_active ? S_PATTERN : S_WRITE;
`else
            state_d = S_WRITE;
`endif
         end
      end

      ready_d = (state_d == S_IDLE) || (state_d == S_WRITE);
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q   <= S_IDLE;
         row_q     <= '0;
         col_q     <= '0;
         bank_q    <= 1'b0;
         ready_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         done_q    <= 1'b0;
         sof_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         bank_q    <= bank_d;
         ready_q   <= ready_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         done_q    <= done_d;
         sof_err_q <= sof_err_d;
      end
   end

   assign ram_write_en_out = we_q;
   assign ram_address_out  = addr_q;
   assign ram_wdata_out    = wdata_q;
   assign display_bank_out = bank_q;
   assign frame_done_out   = done_q;
   assign sof_error_out    = sof_err_q;

endmodule

// File: tb/tb_led_display_frame_writer.sv
// Randomized bench for led_display_frame_writer against a linear-index frame model.
module tb_led_display_frame_writer;

   localparam int ROWS = 32;
   localparam int COLS = 64;
   localparam int FW   = ROWS * COLS;
   localparam int AW   = 13;
   localparam int DW   = 32;
`ifdef LED_FRAME_WRITER_PATTERN_EN
   localparam bit PAT_BUILD = 1'b1;
`else
   localparam bit PAT_BUILD = 1'b0;
`endif

   logic          clk_in = 1'b0;
   logic          reset_in;
   logic [23:0]   pixel_in;
   logic          pixel_valid_in;
   logic          pixel_sof_in;
   logic          pixel_ready_out;
   logic          pattern_start_in;
   logic          frame_sync_in;
   logic          ram_write_en_out;
   logic [AW-1:0] ram_address_out;
   logic [DW-1:0] ram_wdata_out;
   logic          display_bank_out;
   logic          frame_done_out;
   logic          sof_error_out;

   always #5 clk_in = ~clk_in;

   led_display_frame_writer #(
      .NUM_ROW_PIXELS (ROWS),
      .NUM_COL_PIXELS (COLS),
      .RAM_ADDR_WIDTH (AW),
      .RAM_DATA_WIDTH (DW)
   ) dut (
      .clk_in           (clk_in),
      .reset_in         (reset_in),
      .pixel_in         (pixel_in),
      .pixel_valid_in   (pixel_valid_in),
      .pixel_sof_in     (pixel_sof_in),
      .pixel_ready_out  (pixel_ready_out),
      .pattern_start_in (pattern_start_in),
      .frame_sync_in    (frame_sync_in),
      .ram_write_en_out (ram_write_en_out),
      .ram_address_out  (ram_address_out),
      .ram_wdata_out    (ram_wdata_out),
      .display_bank_out (display_bank_out),
      .frame_done_out   (frame_done_out),
      .sof_error_out    (sof_error_out)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Model: 0 idle, 1 filling, 2 waiting for swap, 3 pattern; position is a linear word index.
   int            m_mode;
   int            m_pos;
   bit            m_bank;
   bit            m_err;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   int            we_count;
   int            done_count;

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_bank = 0; m_err = 0; m_addr = '0; m_data = '0;
   endtask

   task automatic cycle(input bit v, input bit sof, input logic [23:0] pix, input bit sync,
                        input bit pat);
      bit exp_ready, acc, wr;
      int wpos;
      logic [23:0] wpix;
      pixel_valid_in = v; pixel_sof_in = sof; pixel_in = pix;
      frame_sync_in = sync; pattern_start_in = pat;
      #3;
      exp_ready = (m_mode == 1) || (m_mode == 0 && !(PAT_BUILD && pat));
      check("ready", pixel_ready_out, exp_ready);
      acc = v && exp_ready; wr = 0; wpos = 0; wpix = '0;
      case (m_mode)
         0: if (PAT_BUILD && pat) begin m_mode = 3; m_pos = 0; end
            else if (acc && sof) begin wr = 1; wpos = 0; wpix = pix; m_mode = 1; end
         1: if (acc) begin
               if (sof) begin m_err = 1; wpos = 0; end else wpos = m_pos;
               wr = 1; wpix = pix;
            end
         2: if (sync) begin m_bank = !m_bank; m_mode = 0; m_pos = 0; end
         3: begin
               wr = 1; wpos = m_pos;
               wpix = {8'((wpos % COLS) * 4), 8'((wpos / COLS) * 8), 8'h00};
            end
         default: ;
      endcase
      if (wr) begin
         m_addr = AW'((m_bank ? 0 : FW) + wpos);
         m_data = DW'(wpix);
         m_pos  = wpos + 1;
         if (wpos == FW - 1) begin m_mode = 2; m_pos = 0; end
      end
      @(posedge clk_in); #1;
      check("we", ram_write_en_out, wr);
      check("addr", ram_address_out, m_addr);
      check("wdata", ram_wdata_out, m_data);
      check("done", frame_done_out, wr && wpos == FW - 1);
      check("bank", display_bank_out, m_bank);
      check("sof_err", sof_error_out, m_err);
      we_count   += int'(ram_write_en_out);
      done_count += int'(frame_done_out);
   endtask

   task automatic apply_reset();
      reset_in = 1'b1;
      pixel_valid_in = 0; pixel_sof_in = 0; pixel_in = '0;
      frame_sync_in = 0; pattern_start_in = 0;
      #1;
      check("rst_ready", pixel_ready_out, 1'b0);
      check("rst_we", ram_write_en_out, 1'b0);
      check("rst_addr", ram_address_out, '0);
      check("rst_wdata", ram_wdata_out, '0);
      check("rst_bank", display_bank_out, 1'b0);
      check("rst_done", frame_done_out, 1'b0);
      check("rst_err", sof_error_out, 1'b0);
      model_reset();
      @(negedge clk_in);
      reset_in = 1'b0;
      @(posedge clk_in); #1;
   endtask

   task automatic stream(input int n, input bit first_sof, input bit idx_data,
                         input bit stalls, input bit sync_on_last);
      for (int i = 0; i < n; i++) begin
         if (stalls)
            while ($urandom_range(3) == 0)
               cycle(0, 1'($urandom_range(1)), 24'($urandom), $urandom_range(7) == 0, 0);
         cycle(1, first_sof && i == 0, idx_data ? 24'(i) : 24'($urandom),
               sync_on_last && i == n - 1, 0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 24'($urandom), 0, 0);
   endtask

   initial begin
      reset_in = 1'b1;
      @(posedge clk_in); #1;
      apply_reset();

      // 1: indexed frame into bank 1
      we_count = 0; done_count = 0;
      stream(FW, 1, 1, 0, 0);
      check("t1_strobes", we_count, FW);
      check("t1_done_pulses", done_count, 1);
      idle(3);

      // 2: swap, then stalled random frame into bank 0 with ignored syncs
      cycle(0, 0, '0, 1, 0);
      check("t2_bank", display_bank_out, 1'b1);
      we_count = 0;
      stream(FW, 1, 0, 1, 0);
      check("t2_strobes", we_count, FW);
      cycle(0, 0, '0, 1, 0);

      // 3: non-SOF pixels in IDLE are discarded
      we_count = 0;
      for (int i = 0; i < 5; i++) cycle(1, 0, 24'($urandom), 0, 0);
      check("t3_no_writes", we_count, 0);

      // 4: SOF mid-frame restarts and sets the sticky error
      stream(100, 1, 0, 0, 0);
      cycle(1, 1, 24'($urandom), 0, 0);
      check("t4_err", sof_error_out, 1'b1);
      check("t4_restart_addr", ram_address_out, 13'h800);
      stream(FW - 1, 0, 0, 1, 0);
      cycle(0, 0, '0, 1, 0);

      // 5: sync coincident with last acceptance is ignored
      stream(FW, 1, 0, 1, 1);
      idle(4);
      check("t5_no_swap", display_bank_out, 1'b1);
      cycle(0, 0, '0, 1, 0);
      check("t5_swap", display_bank_out, 1'b0);

      // 6: reset mid-frame, new frame starts at bank 1 base
      stream(300, 1, 0, 1, 0);
      apply_reset();
      stream(50, 1, 0, 1, 0);
      check("t6_first_write_count", we_count > 0, 1'b1);

`ifdef LED_FRAME_WRITER_PATTERN_EN
      apply_reset();
      cycle(0, 0, '0, 0, 1);
      for (int k = 0; k < FW + 10 && m_mode != 2; k++) begin
         cycle(0, 0, '0, 0, 0);
         if (ram_write_en_out && ram_address_out == 13'h8C5)
            check("pat_8c5", ram_wdata_out, 32'h0014_1800);
      end
      check("pat_done", m_mode, 2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
